pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised pipeline stage register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces the fixed-width enable/clear stage registers with a valid/ready elastic stage.
//  Adds an optional 2-entry skid buffer, a flush that kills in-flight beats and a
//  saturating stall counter for CPI statistics.
//  Sits between two adjacent pipeline stages; the payload is the concatenated stage bundle.
// PARAMETERS
//  DATA_W    234  payload width in bits (default = full EX/MEM bundle)
//  SKID      1    1: 2-entry skid buffer, registered out_READY; 0: single register, legacy enable style
//  CLR_DATA  1    1: flush/reset zero the payload (zero control word = NOP); 0: payload held, only valid cleared
//  CNT_W     16   stall counter width
// PORTS
//  in_CLK         in   1       rising-edge clock
//  in_RST_N       in   1       asynchronous active-low reset
//  in_VALID       in   1       upstream beat valid
//  in_DATA        in   DATA_W  upstream payload
//  out_READY      out  1       stage can accept a beat this cycle
//  out_VALID      out  1       downstream beat valid
//  out_DATA       out  DATA_W  downstream payload
//  in_READY       in   1       downstream accepts (0 = stall)
//  in_FLUSH       in   1       synchronous kill of all held beats (branch mispredict / exception)
//  in_CNT_CLR     in   1       synchronous clear of stall counter
//  out_STALL_CNT  out  CNT_W   cycles with out_VALID=1 and in_READY=0, saturating
// BEHAVIOUR
//  - Reset (in_RST_N=0, async): state EMPTY, out_VALID=0, out_DATA=0, skid reg=0, out_STALL_CNT=0;
//    out_READY=1 immediately.
//  - acc = in_VALID & out_READY; take = out_VALID & in_READY.
//  - SKID=1 FSM, out_READY = (state!=FULL), registered-state decode only (no in_READY path):
//      EMPTY: acc -> ONE, main<=in_DATA
//      ONE:   acc&take -> ONE, main<=in_DATA; acc&!take -> FULL, skid<=in_DATA;
//             !acc&take -> EMPTY; else hold
//      FULL:  take -> ONE, main<=skid; else hold
//    out_VALID = (state!=EMPTY); out_DATA = main. Latency 1 cycle; throughput 1 beat/cycle.
//  - SKID=0: single register; out_READY = !out_VALID | in_READY (combinational);
//    acc loads main, take without acc empties.
//  - Beats leave strictly in arrival order; no beat duplicated or dropped except by flush.
//  - While out_VALID=1 & in_READY=0, out_DATA stays stable.
//  - in_FLUSH=1 at an edge: state->EMPTY, out_VALID=0 next cycle; main/skid zeroed if CLR_DATA.
//    Beats accepted in the same cycle are discarded; flush beats take and acc.
//  - Stall counter: +1 per edge when out_VALID & !in_READY & !in_FLUSH; saturates at 2^CNT_W-1.
//    in_CNT_CLR wins over increment. Counter is not cleared by flush.
//  - Reset asserted mid-transfer: all beats lost, outputs at reset values, no X on outputs.
// STRUCTURE
//  - pipe_pkg: state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b11), default DATA_W/CNT_W,
//    EX/MEM bundle field offsets (lock, is, pcout, ra, rb, R, p2..p4, control, BPCOUT).
//  - Sub-module pipe_sat_counter (CNT_W, inc, clr, async active-low reset) for the stall counter.
//  - FSM, main/skid registers and ready/valid decode stay in this module.
// TESTING
//  1 Reset: in_RST_N=0 with in_VALID=1, in_DATA=all-ones -> out_VALID=0, out_DATA=0,
//    out_READY=1, out_STALL_CNT=0.
//  2 Streaming SKID=1: in_READY=1, beats 1..8 back-to-back -> out_DATA 1..8 on consecutive
//    cycles, 1 cycle after input, out_READY never 0.
//  3 Backpressure: send 5,6,7 with in_READY=0 -> 5 held on out, 6 in skid, out_READY=0 after 6,
//    7 not accepted; release in_READY -> 5,6,7 delivered in order; out_STALL_CNT = stall cycles.
//  4 Flush in FULL: in_FLUSH=1 with in_VALID=1 (data 9) -> next cycle out_VALID=0, out_DATA=0,
//    out_READY=1, beat 9 absent.
//  5 Counter: hold out_VALID=1, in_READY=0 for 70000 cycles (CNT_W=16) -> 65535;
//    in_CNT_CLR=1 during a stall -> 0 next cycle.
//  6 SKID=0: in_READY=0 while full -> out_READY=0 in the same cycle;
//    in_READY=1 with in_VALID=1 -> replace in one cycle, no bubble.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding, default widths
// and the EX/MEM bundle field layout (LSB offsets, bit 0 = BPCOUT[0]).
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_e;

   localparam int unsigned DEF_DATA_W = 234;
   localparam int unsigned DEF_CNT_W  = 16;

   localparam int unsigned EXMEM_BPCOUT_LSB  = 0;
   localparam int unsigned EXMEM_BPCOUT_W    = 32;
   localparam int unsigned EXMEM_CONTROL_LSB = 32;
   localparam int unsigned EXMEM_CONTROL_W   = 26;
   localparam int unsigned EXMEM_P4_LSB      = 58;
   localparam int unsigned EXMEM_P3_LSB      = 63;
   localparam int unsigned EXMEM_P2_LSB      = 68;
   localparam int unsigned EXMEM_PX_W        = 5;
   localparam int unsigned EXMEM_R_LSB       = 73;
   localparam int unsigned EXMEM_RB_LSB      = 105;
   localparam int unsigned EXMEM_RA_LSB      = 137;
   localparam int unsigned EXMEM_PCOUT_LSB   = 169;
   localparam int unsigned EXMEM_IS_LSB      = 201;
   localparam int unsigned EXMEM_WORD_W      = 32;
   localparam int unsigned EXMEM_LOCK_LSB    = 233;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle between two adjacent pipeline stages, plus flush.
interface pipe_stage_elastic_if
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              in_VALID;
   logic [DATA_W-1:0] in_DATA;
   logic              out_READY;
   logic              out_VALID;
   logic [DATA_W-1:0] out_DATA;
   logic              in_READY;
   logic              in_FLUSH;

   modport master (
      output in_VALID, in_DATA, in_READY, in_FLUSH,
      input  out_READY, out_VALID, out_DATA
   );

   modport slave (
      input  in_VALID, in_DATA, in_READY, in_FLUSH,
      output out_READY, out_VALID, out_DATA
   );
endinterface

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module pipe_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             in_CLK,
   input  logic             in_RST_N,
   input  logic             in_INC,
   input  logic             in_CLR,
   output logic [CNT_W-1:0] out_CNT
);
   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         r_cnt <= '0;
      end else if (in_CLR) begin
         r_cnt <= '0;
      end else if (in_INC && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign out_CNT = r_cnt;
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer, flush and
// saturating stall counter.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter bit          SKID     = 1'b1,
   parameter bit          CLR_DATA = 1'b1,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic                 in_CLK,
   input  logic                 in_RST_N,
   pipe_stage_elastic_if.slave  bus,
   input  logic                 in_CNT_CLR,
   output logic [CNT_W-1:0]     out_STALL_CNT
);
   state_e            r_state;
   state_e            w_state_nxt;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic              w_acc;
   logic              w_take;
   logic              w_main_ld;
   logic              w_main_from_skid;
   logic              w_skid_ld;
   logic              w_stall;

   // Without the skid buffer ready looks through to downstream, so ONE never sees acc & !take.
   assign bus.out_READY = SKID ? (r_state != ST_FULL) : (!bus.out_VALID || bus.in_READY);
   assign bus.out_VALID = (r_state != ST_EMPTY);
   assign bus.out_DATA  = r_main;

   assign w_acc   = bus.in_VALID && bus.out_READY;
   assign w_take  = bus.out_VALID && bus.in_READY;
   assign w_stall = bus.out_VALID && !bus.in_READY && !bus.in_FLUSH;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_state_nxt = ST_ONE;
               w_main_ld   = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_acc && w_take) begin
               w_main_ld = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = ST_FULL;
               w_skid_ld   = 1'b1;
            end else if (w_take) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_take) begin
               w_state_nxt      = ST_ONE;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (bus.in_FLUSH) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: payload registers are reset so a zero control word (NOP) is presented after reset.
   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         r_main <= '0;
         r_skid <= '0;
      end else if (bus.in_FLUSH) begin
         if (CLR_DATA) begin
            r_main <= '0;
            r_skid <= '0;
         end
      end else begin
         if (w_main_ld) begin
            r_main <= bus.in_DATA;
         end else if (w_main_from_skid) begin
            r_main <= r_skid;
         end
         if (w_skid_ld) begin
            r_skid <= bus.in_DATA;
         end
      end
   end

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .in_CLK   (in_CLK),
      .in_RST_N (in_RST_N),
      .in_INC   (w_stall),
      .in_CLR   (in_CNT_CLR),
      .out_CNT  (out_STALL_CNT)
   );
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a skid instance (234-bit, 16-bit counter)
// and a legacy single-register instance (8-bit, CLR_DATA=0, 4-bit counter).
module tb_pipe_stage_elastic;
   import pipe_pkg::*;

   localparam int unsigned DW_S = 234;
   localparam int unsigned DW_L = 8;
   localparam int unsigned CW_S = 16;
   localparam int unsigned CW_L = 4;

   logic            in_CLK;
   logic            in_RST_N;
   logic            cnt_clr_s;
   logic            cnt_clr_l;
   logic [CW_S-1:0] stall_cnt_s;
   logic [CW_L-1:0] stall_cnt_l;

   int n_vec = 0;
   int n_err = 0;

   pipe_stage_elastic_if #(.DATA_W(DW_S)) bus_s ();
   pipe_stage_elastic_if #(.DATA_W(DW_L)) bus_l ();

   pipe_stage_elastic #(
      .DATA_W(DW_S), .SKID(1'b1), .CLR_DATA(1'b1), .CNT_W(CW_S)
   ) u_dut_s (
      .in_CLK        (in_CLK),
      .in_RST_N      (in_RST_N),
      .bus           (bus_s),
      .in_CNT_CLR    (cnt_clr_s),
      .out_STALL_CNT (stall_cnt_s)
   );

   pipe_stage_elastic #(
      .DATA_W(DW_L), .SKID(1'b0), .CLR_DATA(1'b0), .CNT_W(CW_L)
   ) u_dut_l (
      .in_CLK        (in_CLK),
      .in_RST_N      (in_RST_N),
      .bus           (bus_l),
      .in_CNT_CLR    (cnt_clr_l),
      .out_STALL_CNT (stall_cnt_l)
   );

   initial in_CLK = 1'b0;
   always #5 in_CLK = ~in_CLK;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      in_RST_N        = 1'b0;
      cnt_clr_s       = 1'b0;
      cnt_clr_l       = 1'b0;
      bus_s.in_VALID  = 1'b1;
      bus_s.in_DATA   = '1;
      bus_s.in_READY  = 1'b1;
      bus_s.in_FLUSH  = 1'b0;
      bus_l.in_VALID  = 1'b1;
      bus_l.in_DATA   = '1;
      bus_l.in_READY  = 1'b1;
      bus_l.in_FLUSH  = 1'b0;

      // Reset with an all-ones beat offered upstream
      @(negedge in_CLK);
      check("rst_valid", 256'(bus_s.out_VALID), 256'(0));
      check("rst_data",  256'(bus_s.out_DATA),  256'(0));
      check("rst_ready", 256'(bus_s.out_READY), 256'(1));
      check("rst_cnt",   256'(stall_cnt_s),     256'(0));
      check("rst_l_valid", 256'(bus_l.out_VALID), 256'(0));
      bus_s.in_VALID = 1'b0;
      bus_l.in_VALID = 1'b0;
      in_RST_N       = 1'b1;
      @(negedge in_CLK);

      // Streaming 1..8, one cycle latency, no back-pressure
      for (int i = 1; i <= 8; i++) begin
         bus_s.in_VALID = 1'b1;
         bus_s.in_DATA  = DW_S'(i);
         @(negedge in_CLK);
         check($sformatf("stream_data_%0d", i), 256'(bus_s.out_DATA), 256'(i));
         check($sformatf("stream_rdy_%0d", i),  256'(bus_s.out_READY), 256'(1));
      end
      bus_s.in_VALID = 1'b0;
      @(negedge in_CLK);
      check("stream_drained", 256'(bus_s.out_VALID), 256'(0));

      // Back-pressure: 5 on output, 6 in skid, 7 refused until release
      bus_s.in_READY = 1'b0;
      bus_s.in_VALID = 1'b1;
      bus_s.in_DATA  = DW_S'(5);
      @(negedge in_CLK);
      check("bp_hold5",   256'(bus_s.out_DATA),  256'(5));
      check("bp_rdy_one", 256'(bus_s.out_READY), 256'(1));
      bus_s.in_DATA = DW_S'(6);
      @(negedge in_CLK);
      check("bp_full_rdy", 256'(bus_s.out_READY), 256'(0));
      check("bp_full_out", 256'(bus_s.out_DATA),  256'(5));
      bus_s.in_DATA = DW_S'(7);
      @(negedge in_CLK);
      check("bp_still5", 256'(bus_s.out_DATA), 256'(5));
      check("bp_cnt2",   256'(stall_cnt_s),     256'(2));
      bus_s.in_READY = 1'b1;
      @(negedge in_CLK);
      check("bp_out6", 256'(bus_s.out_DATA),  256'(6));
      check("bp_rdy6", 256'(bus_s.out_READY), 256'(1));
      @(negedge in_CLK);
      check("bp_out7", 256'(bus_s.out_DATA), 256'(7));
      bus_s.in_VALID = 1'b0;
      @(negedge in_CLK);
      check("bp_empty", 256'(bus_s.out_VALID), 256'(0));
      check("bp_cnt",   256'(stall_cnt_s),     256'(2));

      // Flush while FULL with beat 9 offered
      bus_s.in_READY = 1'b0;
      bus_s.in_VALID = 1'b1;
      bus_s.in_DATA  = DW_S'(10);
      @(negedge in_CLK);
      bus_s.in_DATA = DW_S'(11);
      @(negedge in_CLK);
      check("fl_full", 256'(bus_s.out_READY), 256'(0));
      bus_s.in_FLUSH = 1'b1;
      bus_s.in_DATA  = DW_S'(9);
      @(negedge in_CLK);
      check("fl_valid", 256'(bus_s.out_VALID), 256'(0));
      check("fl_data",  256'(bus_s.out_DATA),  256'(0));
      check("fl_ready", 256'(bus_s.out_READY), 256'(1));
      check("fl_cnt",   256'(stall_cnt_s),     256'(3));
      bus_s.in_FLUSH = 1'b0;
      bus_s.in_VALID = 1'b0;
      bus_s.in_READY = 1'b1;
      @(negedge in_CLK);
      check("fl_no9", 256'(bus_s.out_VALID), 256'(0));

      // Stall counter: clear, count, saturate, clear during stall
      bus_s.in_READY = 1'b0;
      bus_s.in_VALID = 1'b1;
      bus_s.in_DATA  = DW_S'(12);
      @(negedge in_CLK);
      bus_s.in_VALID = 1'b0;
      check("cnt_pre", 256'(stall_cnt_s), 256'(3));
      cnt_clr_s = 1'b1;
      @(negedge in_CLK);
      check("cnt_clr0", 256'(stall_cnt_s), 256'(0));
      cnt_clr_s = 1'b0;
      repeat (100) @(negedge in_CLK);
      check("cnt_100", 256'(stall_cnt_s), 256'(100));
      repeat (65500) @(negedge in_CLK);
      check("cnt_sat",    256'(stall_cnt_s),    256'(65535));
      check("cnt_stable", 256'(bus_s.out_DATA), 256'(12));
      cnt_clr_s = 1'b1;
      @(negedge in_CLK);
      check("cnt_clr_stall", 256'(stall_cnt_s), 256'(0));
      cnt_clr_s      = 1'b0;
      bus_s.in_READY = 1'b1;
      @(negedge in_CLK);
      check("cnt_drain", 256'(bus_s.out_VALID), 256'(0));

      // Legacy single register: combinational ready, bubble-free replace
      bus_l.in_READY = 1'b0;
      bus_l.in_VALID = 1'b1;
      bus_l.in_DATA  = 8'h21;
      @(negedge in_CLK);
      check("l_data21",   256'(bus_l.out_DATA),  256'(8'h21));
      check("l_rdy_stall", 256'(bus_l.out_READY), 256'(0));
      bus_l.in_DATA  = 8'h22;
      bus_l.in_READY = 1'b1;
      #1;
      check("l_rdy_comb", 256'(bus_l.out_READY), 256'(1));
      @(negedge in_CLK);
      check("l_data22",  256'(bus_l.out_DATA),  256'(8'h22));
      check("l_valid22", 256'(bus_l.out_VALID), 256'(1));
      check("l_cnt0",    256'(stall_cnt_l),     256'(0));
      bus_l.in_VALID = 1'b0;
      bus_l.in_READY = 1'b0;
      repeat (20) @(negedge in_CLK);
      check("l_cnt_sat", 256'(stall_cnt_l),    256'(15));
      check("l_hold22",  256'(bus_l.out_DATA), 256'(8'h22));
      bus_l.in_FLUSH = 1'b1;
      @(negedge in_CLK);
      bus_l.in_FLUSH = 1'b0;
      check("l_fl_valid", 256'(bus_l.out_VALID), 256'(0));
      check("l_fl_data",  256'(bus_l.out_DATA),  256'(8'h22));
      check("l_fl_ready", 256'(bus_l.out_READY), 256'(1));

      // Asynchronous reset in the middle of a held beat
      bus_s.in_READY = 1'b0;
      bus_s.in_VALID = 1'b1;
      bus_s.in_DATA  = DW_S'(8'h33);
      @(negedge in_CLK);
      check("ar_loaded", 256'(bus_s.out_VALID), 256'(1));
      #2 in_RST_N = 1'b0;
      #1;
      check("ar_valid", 256'(bus_s.out_VALID), 256'(0));
      check("ar_data",  256'(bus_s.out_DATA),  256'(0));
      check("ar_ready", 256'(bus_s.out_READY), 256'(1));
      check("ar_cnt_l", 256'(stall_cnt_l),     256'(0));
      @(negedge in_CLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
